// File: rtl/dfu_sram_pkg.sv
// Shared types and defaults for the DFU banked data-feed SRAM.
package dfu_sram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } sram_state_t;

  localparam int DFU_DATA_W    = 16;
  localparam int DFU_ADDR_W    = 6;
  localparam int DFU_NUM_BANKS = 4;

  // A single bank still needs a 1-bit index port.
  function automatic int bank_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dfu_sram_bank.sv
// One SRAM bank: single write port, registered read port with write-first bypass.
module dfu_sram_bank #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  // Contents are zeroed by the clear engine in the top, so no per-entry reset here.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
    end
  end

endmodule

// File: rtl/dfu_banked_sram.sv
// Multi-bank data-feed SRAM with hardware clear engine, bank decode and read output mux.
module dfu_banked_sram
  import dfu_sram_pkg::*;
#(
  parameter  int DATA_W    = DFU_DATA_W,
  parameter  int ADDR_W    = DFU_ADDR_W,
  parameter  int NUM_BANKS = DFU_NUM_BANKS,
  localparam int BANK_W    = bank_w(NUM_BANKS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_start,
  input  logic              wr_en,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [BANK_W-1:0] rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_vld,
  output logic              clr_busy,
  output logic              acc_err
);

  localparam int              DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [BANK_W:0] NB       = NUM_BANKS[BANK_W:0];

  sram_state_t       state, state_nxt;
  logic [ADDR_W:0]   clr_addr, clr_addr_nxt;
  logic              wr_bank_ok, rd_bank_ok;
  logic              wr_ok, rd_ok, acc_bad;
  logic [BANK_W-1:0] rd_bank_q;
  logic [ADDR_W-1:0] bank_wr_addr;
  logic [DATA_W-1:0] bank_wr_data;
  logic [DATA_W-1:0] bank_rd_data [NUM_BANKS];

  assign clr_busy   = (state == CLEAR);
  assign wr_bank_ok = ({1'b0, wr_bank} < NB);
  assign rd_bank_ok = ({1'b0, rd_bank} < NB);
  assign wr_ok      = wr_en && !clr_busy && wr_bank_ok;
  assign rd_ok      = rd_en && !clr_busy && rd_bank_ok;
  assign acc_bad    = ((wr_en || rd_en) && clr_busy) ||
                      (wr_en && !wr_bank_ok) || (rd_en && !rd_bank_ok);

  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    case (state)
      CLEAR: begin
        clr_addr_nxt = clr_addr + 1'b1;
        if (clr_addr == CLR_LAST) begin
          state_nxt = READY;
        end
      end
      READY: begin
        if (clr_start) begin
          state_nxt    = CLEAR;
          clr_addr_nxt = '0;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= CLEAR;
      clr_addr  <= '0;
      rd_vld    <= 1'b0;
      rd_bank_q <= '0;
      acc_err   <= 1'b0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
      rd_vld   <= rd_ok;
      if (rd_ok) begin
        rd_bank_q <= rd_bank;
      end
      if (acc_bad) begin
        acc_err <= 1'b1;
      end
    end
  end

  // While clearing, every bank is written with zero at the sweep address.
  assign bank_wr_addr = clr_busy ? clr_addr[ADDR_W-1:0] : wr_addr;
  assign bank_wr_data = clr_busy ? '0 : wr_data;

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    dfu_sram_bank #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .clk     (clk),
      .wr_en   (clr_busy || (wr_ok && (wr_bank == BANK_W'(g)))),
      .wr_addr (bank_wr_addr),
      .wr_data (bank_wr_data),
      .rd_en   (rd_ok && (rd_bank == BANK_W'(g))),
      .rd_addr (rd_addr),
      .rd_data (bank_rd_data[g])
    );
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (rd_vld && (rd_bank_q == BANK_W'(i))) begin
        rd_data = bank_rd_data[i];
      end
    end
  end

endmodule
